l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

Two-requester arbiter that shares a single L2 cache request port between two L1 cache controllers (requester 0, requester 1). Each L1 raises read (line fill), write (inclusion-policy word write) or write-back (dirty line eviction) requests. The arbiter grants one requester at a time using round-robin fairness and latches that requester's command, address and data. It holds the grant until the L2 returns the matching completion or a watchdog expires, and routes each completion only to the granted requester.

## Interface
- ADDRESS_WIDTH, 32, request address width
- DATA_WIDTH, 32, word width for write requests
- LINE_WIDTH, 128, cache line width for fills and write-backs
- TIMEOUT_CYCLES, 1023, maximum GRANT cycles before abort (≥1)
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- reqN_read, reqN_write, reqN_write_back  in  1 each  request strobes from requester N (N = 0, 1), level, held until completion
- reqN_address  in  ADDRESS_WIDTH  request address
- reqN_write_data  in  DATA_WIDTH  word for write
- reqN_write_back_data  in  LINE_WIDTH  line for write-back
- reqN_ready  out  1  read completion to N
- reqN_read_line  out  LINE_WIDTH  fill data to N, zero unless reqN_ready
- reqN_write_verified, reqN_write_back_verified  out  1 each  completions to N
- l2_read_request, l2_write_request, l2_write_back_request  out  1 each  command to L2, at most one high
- l2_address  out  ADDRESS_WIDTH; l2_write_data  out  DATA_WIDTH; l2_write_back_data  out  LINE_WIDTH  latched operands
- l2_ready, l2_write_verified, l2_write_back_verified  in  1 each  L2 completion pulses
- l2_read_line  in  LINE_WIDTH  fill data valid with l2_ready
- grant_id  out  1  currently or last granted requester
- busy  out  1  high in GRANT and RELEASE
- timeout  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: requester N is "pending" if any of its three strobes is high.
  - One pending: grant it.
  - Both pending: grant the one that is not last_grant.
  - On the edge: latch grant_id, op, address, write data and write-back line; clear the watchdog; go to GRANT.
- Op priority within a requester when several strobes are high: write_back > write > read.
- GRANT: drive exactly the latched op's l2_* request plus the latched operands.
  - Completion matching the latched op (read: l2_ready, write: l2_write_verified, write-back: l2_write_back_verified) is forwarded combinationally, same cycle, to reqG only. l2_read_line passes through with l2_ready.
  - On a matching completion: last_grant <= G, go to RELEASE.
  - Non-matching completion pulses are ignored and never forwarded.
- Watchdog: counts GRANT cycles. When the count reaches TIMEOUT_CYCLES without a completion: pulse timeout, forward nothing, last_grant <= G, go to RELEASE.
- RELEASE: one cycle with all l2_* requests low and all reqN_* outputs low. Requests are not sampled. Next state is IDLE.
- Requester drops its strobe during GRANT: the transaction continues on latched values; a later completion is still forwarded.
- Strobes of the non-granted requester are ignored until IDLE.
- Latched operands are not updated during GRANT, even if reqN inputs change.
- Reset (any time, including mid-GRANT): state IDLE, last_grant = 1 (requester 0 wins the first tie), grant_id = 0, watchdog = 0. All outputs 0; l2_* operands 0.

## Timing
- Request seen in IDLE at edge k → l2_*_request high from cycle k+1 (registered state, registered operands).
- Completion at cycle m → reqG_* response high in cycle m (combinational), RELEASE in m+1, IDLE in m+2.
- Minimum turnaround: 3 cycles per transaction when L2 completes in the first GRANT cycle.
- Back-to-back contention alternates 0,1,0,1; no requester waits more than one transaction.
- Timeout pulse occurs in the TIMEOUT_CYCLES-th GRANT cycle; l2 requests are low from the next cycle.
- busy and grant_id are registered; l2 request outputs are decoded from registered state and op only, with no combinational input-to-l2 path.

## Test plan
- Single read, requester 0, address 0x0000_1040: l2_read_request rises 1 cycle later with l2_address 0x0000_1040. l2_ready with line 0xA5…A5 → req0_ready and req0_read_line equal that line the same cycle; req1 outputs stay 0.
- Simultaneous after reset: req0_read and req1_write both high. Requester 0 is served first, then requester 1. With both held, a third transaction goes to requester 0.
- Requester 1 asserts write and write_back at once (line 0xDEAD…): only l2_write_back_request asserts, carrying the line. A spurious l2_write_verified during GRANT is not forwarded.
- TIMEOUT_CYCLES = 8, L2 silent: timeout pulses in the 8th GRANT cycle, requests drop, and the other pending requester is granted after RELEASE.
- Reset asserted mid-GRANT: all outputs are 0 immediately (asynchronous). After release, a tie is granted to requester 0.
- Requester 0 changes its address in the middle of GRANT: l2_address keeps the latched value until completion.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between two L1 controllers.
// Holds the grant until the matching L2 completion or a watchdog abort.
module l2_port_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_read,
  input  logic                     req0_write,
  input  logic                     req0_write_back,
  input  logic [ADDRESS_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0]    req0_write_data,
  input  logic [LINE_WIDTH-1:0]    req0_write_back_data,
  output logic                     req0_ready,
  output logic [LINE_WIDTH-1:0]    req0_read_line,
  output logic                     req0_write_verified,
  output logic                     req0_write_back_verified,
  input  logic                     req1_read,
  input  logic                     req1_write,
  input  logic                     req1_write_back,
  input  logic [ADDRESS_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0]    req1_write_data,
  input  logic [LINE_WIDTH-1:0]    req1_write_back_data,
  output logic                     req1_ready,
  output logic [LINE_WIDTH-1:0]    req1_read_line,
  output logic                     req1_write_verified,
  output logic                     req1_write_back_verified,
  output logic                     l2_read_request,
  output logic                     l2_write_request,
  output logic                     l2_write_back_request,
  output logic [ADDRESS_WIDTH-1:0] l2_address,
  output logic [DATA_WIDTH-1:0]    l2_write_data,
  output logic [LINE_WIDTH-1:0]    l2_write_back_data,
  input  logic                     l2_ready,
  input  logic                     l2_write_verified,
  input  logic                     l2_write_back_verified,
  input  logic [LINE_WIDTH-1:0]    l2_read_line,
  output logic                     grant_id,
  output logic                     busy,
  output logic                     timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_WRITE_BACK} op_t;

  // The watchdog only needs to reach TIMEOUT_CYCLES-1 (first GRANT cycle counts as 0).
  localparam int WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              state;
  op_t                 op;
  op_t                 sel_op;
  logic                last_grant;
  logic [WD_WIDTH-1:0] watchdog;
  logic                pend0;
  logic                pend1;
  logic                pick;
  logic                in_grant;
  logic                completion_match;
  logic                watchdog_expired;

  assign pend0 = req0_read | req0_write | req0_write_back;
  assign pend1 = req1_read | req1_write | req1_write_back;
  assign pick  = pend1 & (~pend0 | ~last_grant);

  always_comb begin
    sel_op = OP_READ;
    if (pick ? req1_write_back : req0_write_back)
      sel_op = OP_WRITE_BACK;
    else if (pick ? req1_write : req0_write)
      sel_op = OP_WRITE;
  end

  assign in_grant = (state == GRANT);
  assign completion_match = in_grant & (((op == OP_READ) & l2_ready) |
                                        ((op == OP_WRITE) & l2_write_verified) |
                                        ((op == OP_WRITE_BACK) & l2_write_back_verified));
  assign watchdog_expired = in_grant & ~completion_match & (watchdog == WD_LAST);
  assign timeout = watchdog_expired;

  assign l2_read_request       = in_grant & (op == OP_READ);
  assign l2_write_request      = in_grant & (op == OP_WRITE);
  assign l2_write_back_request = in_grant & (op == OP_WRITE_BACK);

  assign req0_ready               = completion_match & ~grant_id & (op == OP_READ);
  assign req0_write_verified      = completion_match & ~grant_id & (op == OP_WRITE);
  assign req0_write_back_verified = completion_match & ~grant_id & (op == OP_WRITE_BACK);
  assign req1_ready               = completion_match & grant_id & (op == OP_READ);
  assign req1_write_verified      = completion_match & grant_id & (op == OP_WRITE);
  assign req1_write_back_verified = completion_match & grant_id & (op == OP_WRITE_BACK);
  assign req0_read_line = req0_ready ? l2_read_line : '0;
  assign req1_read_line = req1_ready ? l2_read_line : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      op                 <= OP_READ;
      last_grant         <= 1'b1;
      grant_id           <= 1'b0;
      busy               <= 1'b0;
      watchdog           <= '0;
      l2_address         <= '0;
      l2_write_data      <= '0;
      l2_write_back_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend0 | pend1) begin
            grant_id           <= pick;
            op                 <= sel_op;
            l2_address         <= pick ? req1_address : req0_address;
            l2_write_data      <= pick ? req1_write_data : req0_write_data;
            l2_write_back_data <= pick ? req1_write_back_data : req0_write_back_data;
            watchdog           <= '0;
            busy               <= 1'b1;
            state              <= GRANT;
          end
        end
        GRANT: begin
          if (completion_match | watchdog_expired) begin
            last_grant <= grant_id;
            state      <= RELEASE;
          end else begin
            watchdog <= watchdog + WD_WIDTH'(1);
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized bench for l2_port_arbiter against a transaction-level model
// of round-robin selection, op priority, latching and watchdog abort.
module tb_l2_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 128;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic          req0_read, req0_write, req0_write_back;
  logic [AW-1:0] req0_address;
  logic [DW-1:0] req0_write_data;
  logic [LW-1:0] req0_write_back_data;
  logic          req0_ready, req0_write_verified, req0_write_back_verified;
  logic [LW-1:0] req0_read_line;
  logic          req1_read, req1_write, req1_write_back;
  logic [AW-1:0] req1_address;
  logic [DW-1:0] req1_write_data;
  logic [LW-1:0] req1_write_back_data;
  logic          req1_ready, req1_write_verified, req1_write_back_verified;
  logic [LW-1:0] req1_read_line;
  logic          l2_read_request, l2_write_request, l2_write_back_request;
  logic [AW-1:0] l2_address;
  logic [DW-1:0] l2_write_data;
  logic [LW-1:0] l2_write_back_data;
  logic          l2_ready, l2_write_verified, l2_write_back_verified;
  logic [LW-1:0] l2_read_line;
  logic          grant_id, busy, timeout;

  logic [5:0] resp;
  logic [2:0] l2_req;
  assign resp   = {req1_write_back_verified, req1_write_verified, req1_ready,
                   req0_write_back_verified, req0_write_verified, req0_ready};
  assign l2_req = {l2_write_back_request, l2_write_request, l2_read_request};

  int checks = 0;
  int errors = 0;

  logic [2:0]    strobe [2];
  logic [AW-1:0] addr_m [2];
  logic [DW-1:0] wdata_m [2];
  logic [LW-1:0] wb_m [2];
  bit            last_grant_m;

  l2_port_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_read(req0_read), .req0_write(req0_write), .req0_write_back(req0_write_back),
    .req0_address(req0_address), .req0_write_data(req0_write_data),
    .req0_write_back_data(req0_write_back_data),
    .req0_ready(req0_ready), .req0_read_line(req0_read_line),
    .req0_write_verified(req0_write_verified), .req0_write_back_verified(req0_write_back_verified),
    .req1_read(req1_read), .req1_write(req1_write), .req1_write_back(req1_write_back),
    .req1_address(req1_address), .req1_write_data(req1_write_data),
    .req1_write_back_data(req1_write_back_data),
    .req1_ready(req1_ready), .req1_read_line(req1_read_line),
    .req1_write_verified(req1_write_verified), .req1_write_back_verified(req1_write_back_verified),
    .l2_read_request(l2_read_request), .l2_write_request(l2_write_request),
    .l2_write_back_request(l2_write_back_request),
    .l2_address(l2_address), .l2_write_data(l2_write_data), .l2_write_back_data(l2_write_back_data),
    .l2_ready(l2_ready), .l2_write_verified(l2_write_verified),
    .l2_write_back_verified(l2_write_back_verified), .l2_read_line(l2_read_line),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] s0, input logic [2:0] s1);
    strobe[0] = s0;
    strobe[1] = s1;
    for (int n = 0; n < 2; n++) begin
      addr_m[n]  = $urandom;
      wdata_m[n] = $urandom;
      wb_m[n]    = rand_line();
    end
    {req0_write_back, req0_write, req0_read} = s0;
    {req1_write_back, req1_write, req1_read} = s1;
    req0_address = addr_m[0]; req0_write_data = wdata_m[0]; req0_write_back_data = wb_m[0];
    req1_address = addr_m[1]; req1_write_data = wdata_m[1]; req1_write_back_data = wb_m[1];
  endtask

  // Called at an IDLE negedge with strobes applied; returns at the next IDLE negedge.
  task automatic runTransaction(input int latency);
    int            w;
    int            op;
    bit            done;
    bit            match;
    logic [2:0]    comp;
    logic [LW-1:0] line;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [LW-1:0] exp_wb;
    #2;
    checkOutput("idle_busy", LW'(busy), LW'(0));
    checkOutput("idle_l2_req", LW'(l2_req), LW'(0));
    w  = (strobe[1] != 3'b000 && (strobe[0] == 3'b000 || !last_grant_m)) ? 1 : 0;
    op = strobe[w][2] ? 2 : (strobe[w][1] ? 1 : 0);
    exp_addr  = addr_m[w];
    exp_wdata = wdata_m[w];
    exp_wb    = wb_m[w];
    done = 1'b0;
    for (int c = 1; c <= TO + 2 && !done; c++) begin
      @(negedge clk);
      req0_address = $urandom; req1_address = $urandom;
      req0_write_data = $urandom; req1_write_data = $urandom;
      req0_write_back_data = rand_line(); req1_write_back_data = rand_line();
      if ($urandom_range(0, 3) == 0) begin
        if (w == 0) {req0_write_back, req0_write, req0_read} = 3'b000;
        else        {req1_write_back, req1_write, req1_read} = 3'b000;
      end
      line  = rand_line();
      match = (c == latency);
      comp  = match ? (3'b001 << op) : (3'($urandom) & ~(3'b001 << op));
      l2_read_line = line;
      {l2_write_back_verified, l2_write_verified, l2_ready} = comp;
      #2;
      checkOutput("grant_busy", LW'(busy), LW'(1));
      checkOutput("grant_id", LW'(grant_id), LW'(w));
      checkOutput("grant_l2_req", LW'(l2_req), LW'(3'b001 << op));
      checkOutput("grant_address", LW'(l2_address), LW'(exp_addr));
      checkOutput("grant_wdata", LW'(l2_write_data), LW'(exp_wdata));
      checkOutput("grant_wb_line", l2_write_back_data, exp_wb);
      checkOutput("grant_resp", LW'(resp), match ? LW'(6'b1 << (3 * w + op)) : LW'(0));
      checkOutput("read_line0", req0_read_line, (match && op == 0 && w == 0) ? line : LW'(0));
      checkOutput("read_line1", req1_read_line, (match && op == 0 && w == 1) ? line : LW'(0));
      checkOutput("timeout", LW'(timeout), LW'(!match && c == TO));
      done = match || (c == TO);
    end
    last_grant_m = (w == 1);
    @(negedge clk);
    {l2_write_back_verified, l2_write_verified, l2_ready} = 3'($urandom);
    l2_read_line = rand_line();
    #2;
    checkOutput("release_busy", LW'(busy), LW'(1));
    checkOutput("release_l2_req", LW'(l2_req), LW'(0));
    checkOutput("release_resp", LW'(resp), LW'(0));
    checkOutput("release_line", req0_read_line | req1_read_line, LW'(0));
    checkOutput("release_timeout", LW'(timeout), LW'(0));
    @(negedge clk);
    {l2_write_back_verified, l2_write_verified, l2_ready} = 3'b000;
  endtask

  initial begin
    logic [2:0] s0;
    logic [2:0] s1;
    reset = 1'b1;
    last_grant_m = 1'b1;
    applyStimulus(3'b000, 3'b000);
    {l2_write_back_verified, l2_write_verified, l2_ready} = 3'b000;
    l2_read_line = '0;
    #2;
    checkOutput("reset_busy", LW'(busy), LW'(0));
    checkOutput("reset_grant_id", LW'(grant_id), LW'(0));
    checkOutput("reset_l2_req", LW'(l2_req), LW'(0));
    checkOutput("reset_address", LW'(l2_address), LW'(0));
    checkOutput("reset_wb_line", l2_write_back_data, LW'(0));
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(3'b001, 3'b000);
    addr_m[0] = 32'h0000_1040;
    req0_address = addr_m[0];
    runTransaction(1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b001, 3'b010);
      runTransaction(2);
    end

    applyStimulus(3'b000, 3'b110);
    runTransaction(3);

    applyStimulus(3'b001, 3'b100);
    runTransaction(TO + 2);
    applyStimulus(3'b001, 3'b100);
    runTransaction(1);

    applyStimulus(3'b010, 3'b000);
    @(negedge clk);
    l2_write_verified = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", LW'(busy), LW'(0));
    checkOutput("async_reset_l2_req", LW'(l2_req), LW'(0));
    checkOutput("async_reset_resp", LW'(resp), LW'(0));
    checkOutput("async_reset_address", LW'(l2_address), LW'(0));
    @(negedge clk);
    reset = 1'b0;
    l2_write_verified = 1'b0;
    last_grant_m = 1'b1;
    applyStimulus(3'b100, 3'b001);
    runTransaction(1);

    for (int i = 0; i < 40; i++) begin
      s0 = 3'($urandom);
      s1 = 3'($urandom);
      if (s0 == 3'b000 && s1 == 3'b000) s0 = 3'b001;
      applyStimulus(s0, s1);
      runTransaction($urandom_range(1, TO + 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
